// File: rtl/regfile_mp_scoreboard_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Imported by the scoreboard and the register-file top.
package regfile_pkg;

  localparam int DEF_DW     = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 2;
  localparam int ZERO_IDX   = 0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard_reg_scoreboard.sv
// Per-register pending scoreboard with flush and a running count.
// PendNext is the post-edge view used by the read ports.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = clog2(DEF_DEPTH),
  parameter int CW    = clog2(DEF_DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             WrOk,
  input  logic [AW-1:0]    WrAddr,
  input  logic             IssOk,
  input  logic [AW-1:0]    IssueAddr,
  input  logic             Flush,
  output logic [DEPTH-1:0] PendNext,
  output logic [CW-1:0]    PendCount
);

  logic [DEPTH-1:0] pendQ;
  logic [CW-1:0]    cntNext;
  logic             inc;
  logic             dec;

  // Next pending vector: flush, then write clears, then issue sets.
  always_comb begin
    PendNext = Flush ? '0 : pendQ;
    if (WrOk) PendNext[WrAddr] = 1'b0;
    if (IssOk) PendNext[IssueAddr] = 1'b1;
  end

  // Incremental count so it never needs a full popcount per cycle.
  always_comb begin
    inc = IssOk & ~pendQ[IssueAddr];
    dec = WrOk & pendQ[WrAddr]
        & ~(IssOk & (IssueAddr == WrAddr));
    if (Flush)
      cntNext = IssOk ? CW'(1) : '0;
    else
      cntNext = PendCount + CW'(inc) - CW'(dec);
  end

  // Scoreboard state registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pendQ     <= '0;
      PendCount <= '0;
    end else begin
      pendQ     <= PendNext;
      PendCount <= cntNext;
    end
  end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Parametrised register file with registered, bypassed read ports
// and an integrated pending scoreboard for hazard detection.
module regfile_mp_scoreboard
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                             Clk,
  input  logic                             Rst_n,
  input  logic [NUM_RD*clog2(DEPTH)-1:0]   RdAddr,
  output logic [NUM_RD*DW-1:0]             RdData,
  output logic [NUM_RD-1:0]                RdPending,
  input  logic                             WrEn,
  input  logic [clog2(DEPTH)-1:0]          WrAddr,
  input  logic [DW-1:0]                    WrData,
  input  logic                             IssueEn,
  input  logic [clog2(DEPTH)-1:0]          IssueAddr,
  input  logic                             Flush,
  output logic [clog2(DEPTH+1)-1:0]        PendCount
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] pendNext;
  logic             wrOk;
  logic             issOk;

  assign wrOk  = WrEn
               & ~((ZERO_REG != 0) & (WrAddr == AW'(ZERO_IDX)));
  assign issOk = IssueEn
               & ~((ZERO_REG != 0) & (IssueAddr == AW'(ZERO_IDX)));

  reg_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .CW    (CW)
  ) u_sb (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .WrOk      (wrOk),
    .WrAddr    (WrAddr),
    .IssOk     (issOk),
    .IssueAddr (IssueAddr),
    .Flush     (Flush),
    .PendNext  (pendNext),
    .PendCount (PendCount)
  );

  // Data array; register 0 is never written when hard-wired.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wrOk) begin
      mem[WrAddr] <= WrData;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          isZero;
    logic [DW-1:0] dataQ;
    logic          pendQ;

    assign addr   = RdAddr[k*AW +: AW];
    assign isZero = (ZERO_REG != 0) & (addr == AW'(ZERO_IDX));

    // Registered read with write-through bypass.
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        dataQ <= '0;
        pendQ <= 1'b0;
      end else begin
        if (isZero)
          dataQ <= '0;
        else if (wrOk && WrAddr == addr)
          dataQ <= WrData;
        else
          dataQ <= mem[addr];
        pendQ <= ~isZero & pendNext[addr];
      end
    end

    assign RdData[k*DW +: DW] = dataQ;
    assign RdPending[k]       = pendQ;
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed table plus randomized reference-model bench
// for the multi-port register file with scoreboard.
module tb_regfile_mp_scoreboard;

  localparam int DW     = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;
  localparam int CW     = 6;

  logic                 Clk = 1'b0;
  logic                 Rst_n;
  logic [NUM_RD*AW-1:0] RdAddr;
  logic [NUM_RD*DW-1:0] RdData;
  logic [NUM_RD-1:0]    RdPending;
  logic                 WrEn;
  logic [AW-1:0]        WrAddr;
  logic [DW-1:0]        WrData;
  logic                 IssueEn;
  logic [AW-1:0]        IssueAddr;
  logic                 Flush;
  logic [CW-1:0]        PendCount;

  int checks = 0;
  int failures = 0;

  regfile_mp_scoreboard #(
    .DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .RdAddr(RdAddr), .RdData(RdData),
    .RdPending(RdPending), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrData(WrData), .IssueEn(IssueEn), .IssueAddr(IssueAddr),
    .Flush(Flush), .PendCount(PendCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [AW-1:0] ra0, ra1;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          ie;
    logic [AW-1:0] ia;
    logic          fl;
    logic [DW-1:0] ed0, ed1;
    logic          ep0, ep1;
    logic [CW-1:0] ec;
  } vec_t;

  vec_t tbl[15];

  // reference model state
  logic [DW-1:0] mRegs [DEPTH];
  bit            mPend [DEPTH];

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    WrEn = 0; WrAddr = '0; WrData = '0;
    IssueEn = 0; IssueAddr = '0; Flush = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic doReset();
    idle();
    RdAddr = '0;
    Rst_n = 0;
    #12;
    @(negedge Clk);
    Rst_n = 1;
    for (int i = 0; i < DEPTH; i++) begin
      mRegs[i] = '0;
      mPend[i] = 0;
    end
  endtask

  // Model: applies one clock edge from the rules, returns nothing.
  task automatic modelEdge();
    bit wok, iok;
    wok = WrEn && WrAddr != 0;
    iok = IssueEn && IssueAddr != 0;
    if (wok) mRegs[WrAddr] = WrData;
    if (Flush)
      for (int i = 0; i < DEPTH; i++) mPend[i] = 0;
    if (wok) mPend[WrAddr] = 0;
    if (iok) mPend[IssueAddr] = 1;
  endtask

  function automatic int modelCount();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(mPend[i]);
    return n;
  endfunction

  initial begin
    tbl[0]  = '{5, 5, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{7, 5, 1, 7, 32'hDEADBEEF, 0, 0, 0,
                32'hDEADBEEF, 0, 0, 0, 0};
    tbl[2]  = '{7, 7, 0, 0, 0,            0, 0, 0,
                32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 32'h1234,     1, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 7, 0, 0, 0,            0, 0, 0,
                0, 32'hDEADBEEF, 0, 0, 0};
    tbl[5]  = '{3, 4, 0, 0, 0,            1, 3, 0, 0, 0, 1, 0, 1};
    tbl[6]  = '{3, 4, 0, 0, 0,            1, 4, 0, 0, 0, 1, 1, 2};
    tbl[7]  = '{5, 4, 0, 0, 0,            1, 5, 0, 0, 0, 1, 1, 3};
    tbl[8]  = '{4, 6, 1, 4, 32'h44,       1, 6, 0, 32'h44, 0, 0, 1, 3};
    tbl[9]  = '{9, 3, 1, 9, 32'h55,       1, 9, 0, 32'h55, 0, 1, 1, 4};
    tbl[10] = '{5, 3, 1, 5, 32'h66,       1, 3, 0, 32'h66, 0, 0, 1, 3};
    tbl[11] = '{7, 9, 1, 7, 32'h77,       0, 0, 0,
                32'h77, 32'h55, 0, 1, 3};
    tbl[12] = '{8, 2, 0, 0, 0,            1, 8, 0, 0, 0, 1, 0, 4};
    tbl[13] = '{2, 3, 0, 0, 0,            1, 2, 1, 0, 0, 1, 0, 1};
    tbl[14] = '{9, 2, 0, 0, 0,            0, 0, 0, 32'h55, 0, 0, 1, 1};

    doReset();
    #1;
    chk("reset_data", RdData[31:0], '0);
    chk("reset_cnt", DW'(PendCount), '0);

    // directed table
    for (int i = 0; i < 15; i++) begin
      RdAddr    = {tbl[i].ra1, tbl[i].ra0};
      WrEn      = tbl[i].we;
      WrAddr    = tbl[i].wa;
      WrData    = tbl[i].wd;
      IssueEn   = tbl[i].ie;
      IssueAddr = tbl[i].ia;
      Flush     = tbl[i].fl;
      tick();
      chk($sformatf("t%0d_d0", i), RdData[0 +: DW], tbl[i].ed0);
      chk($sformatf("t%0d_d1", i), RdData[DW +: DW], tbl[i].ed1);
      chk($sformatf("t%0d_p0", i), DW'(RdPending[0]), DW'(tbl[i].ep0));
      chk($sformatf("t%0d_p1", i), DW'(RdPending[1]), DW'(tbl[i].ep1));
      chk($sformatf("t%0d_cnt", i), DW'(PendCount), DW'(tbl[i].ec));
    end

    // async reset mid-sequence
    idle();
    IssueEn = 1; IssueAddr = 5;
    RdAddr = {AW'(5), AW'(9)};
    tick();
    IssueEn = 0;
    chk("pre_rst_cnt", DW'(PendCount), 32'd2);
    #2;
    Rst_n = 0;
    #1;
    chk("arst_d0", RdData[0 +: DW], '0);
    chk("arst_d1", RdData[DW +: DW], '0);
    chk("arst_pend", DW'(RdPending), '0);
    chk("arst_cnt", DW'(PendCount), '0);
    @(negedge Clk);
    Rst_n = 1;
    RdAddr = {AW'(7), AW'(9)};
    tick();
    chk("post_rst_d0", RdData[0 +: DW], '0);
    chk("post_rst_d1", RdData[DW +: DW], '0);

    // randomized against model
    doReset();
    for (int c = 0; c < 3000; c++) begin
      logic [AW-1:0] a0, a1;
      WrEn      = ($urandom_range(0, 99) < 45);
      WrAddr    = AW'($urandom_range(0, DEPTH - 1));
      WrData    = $urandom;
      IssueEn   = ($urandom_range(0, 99) < 50);
      IssueAddr = ($urandom_range(0, 3) == 0) ? WrAddr
                : AW'($urandom_range(0, DEPTH - 1));
      Flush     = ($urandom_range(0, 99) < 3);
      a0 = ($urandom_range(0, 2) == 0) ? WrAddr
         : AW'($urandom_range(0, DEPTH - 1));
      a1 = ($urandom_range(0, 3) == 0) ? IssueAddr
         : AW'($urandom_range(0, DEPTH - 1));
      RdAddr = {a1, a0};
      modelEdge();
      tick();
      if (RdData[0 +: DW] !== mRegs[a0] ||
          RdData[DW +: DW] !== mRegs[a1] ||
          RdPending[0] !== mPend[a0] ||
          RdPending[1] !== mPend[a1] ||
          int'(PendCount) != modelCount()) begin
        chk($sformatf("rnd%0d_d0", c), RdData[0 +: DW], mRegs[a0]);
        chk($sformatf("rnd%0d_d1", c), RdData[DW +: DW], mRegs[a1]);
        chk($sformatf("rnd%0d_p", c), DW'(RdPending),
            DW'({mPend[a1], mPend[a0]}));
        chk($sformatf("rnd%0d_cnt", c), DW'(PendCount),
            DW'(modelCount()));
      end else begin
        checks++;
      end
      if (failures > 20) break;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
